// File: rtl/irq_mailbox_router_if.sv
// CPU-side interrupt bus for the mailbox router: per-CPU source words,
// finish flags, delivered words with strobes, and router status.
interface irq_mailbox_router_if #(
    parameter int unsigned CPU_NB = 4
);
    logic [CPU_NB-1:0][31:0] i_irq;
    logic [CPU_NB-1:0]       i_finish;
    logic [CPU_NB-1:0][31:0] o_irq;
    logic [CPU_NB-1:0]       o_irq_valid;
    logic                    o_all_done;
    logic [15:0]             o_drop_cnt;

    modport master (
        output i_irq, i_finish,
        input  o_irq, o_irq_valid, o_all_done, o_drop_cnt
    );

    modport slave (
        input  i_irq, i_finish,
        output o_irq, o_irq_valid, o_all_done, o_drop_cnt
    );
endinterface

// File: rtl/irq_mailbox_router.sv
// Interrupt mailbox router: captures new words per source CPU, arbitrates
// round-robin into a shared FIFO and delivers to the encoded destination.
module irq_mailbox_router #(
    parameter int unsigned CPU_NB     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DST_LSB    = 24,
    parameter int unsigned MIN_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    irq_mailbox_router_if.slave   bus
);
    localparam int unsigned IDX_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int unsigned DROP_W = $clog2(CPU_NB + 2);

    logic [CPU_NB-1:0][31:0] prev;
    logic [CPU_NB-1:0][31:0] pend_word;
    logic [CPU_NB-1:0]       pend;
    logic [31:0]             fifo_word [FIFO_DEPTH];
    logic [IDX_W-1:0]        fifo_dst  [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [IDX_W-1:0]        rr;
    logic [GAP_W-1:0]        gap;

    logic [CPU_NB-1:0]       evt_c;
    logic                    found_c;
    logic [IDX_W-1:0]        win_c;
    logic                    grant_c;
    logic [31:0]             win_word_c;
    logic [7:0]              win_dst_c;
    logic                    bad_dst_c;
    logic                    push_c;
    logic                    pop_c;
    logic [DROP_W-1:0]       drop_inc_c;
    logic [16:0]             drop_sum_c;
    logic [15:0]             drop_next_c;

    // Event detection, round-robin winner search and drop accounting.
    always_comb begin
        evt_c      = '0;
        found_c    = 1'b0;
        win_c      = '0;
        drop_inc_c = '0;
        for (int s = 0; s < int'(CPU_NB); s++) begin
            evt_c[s] = (bus.i_irq[s] != prev[s]) && (bus.i_irq[s] != '0);
        end
        for (int unsigned i = 1; i <= CPU_NB; i++) begin
            int unsigned idx;
            idx = (32'(rr) + i) % CPU_NB;
            if (!found_c && pend[IDX_W'(idx)]) begin
                found_c = 1'b1;
                win_c   = IDX_W'(idx);
            end
        end
        grant_c    = found_c && (count < CNT_W'(FIFO_DEPTH));
        win_word_c = pend_word[win_c];
        win_dst_c  = win_word_c[DST_LSB +: 8];
        bad_dst_c  = win_dst_c >= 8'(CPU_NB);
        push_c     = grant_c && !bad_dst_c;
        pop_c      = (count != '0) && (gap == '0);
        // A new event for the source being granted is not an overwrite.
        for (int s = 0; s < int'(CPU_NB); s++) begin
            if (evt_c[s] && pend[s] && !(grant_c && (win_c == IDX_W'(s)))) begin
                drop_inc_c = drop_inc_c + DROP_W'(1);
            end
        end
        if (grant_c && bad_dst_c) begin
            drop_inc_c = drop_inc_c + DROP_W'(1);
        end
        drop_sum_c  = 17'(bus.o_drop_cnt) + 17'(drop_inc_c);
        drop_next_c = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            fifo_word[wr_ptr] <= win_word_c;
            fifo_dst[wr_ptr]  <= win_dst_c[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev            <= '0;
            pend            <= '0;
            pend_word       <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            rr              <= '0;
            gap             <= '0;
            bus.o_irq       <= '0;
            bus.o_irq_valid <= '0;
            bus.o_all_done  <= 1'b0;
            bus.o_drop_cnt  <= '0;
        end else begin
            prev <= bus.i_irq;
            for (int s = 0; s < int'(CPU_NB); s++) begin
                if (evt_c[s]) begin
                    pend[s]      <= 1'b1;
                    pend_word[s] <= bus.i_irq[s];
                end else if (grant_c && (win_c == IDX_W'(s))) begin
                    pend[s] <= 1'b0;
                end
            end
            if (grant_c) begin
                rr <= win_c;
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);

            // Paced delivery: one strobe, then MIN_GAP idle cycles.
            bus.o_irq_valid <= '0;
            if (pop_c) begin
                bus.o_irq[fifo_dst[rd_ptr]]       <= fifo_word[rd_ptr];
                bus.o_irq_valid[fifo_dst[rd_ptr]] <= 1'b1;
                gap                               <= GAP_W'(MIN_GAP);
            end else if (gap != '0) begin
                gap <= gap - GAP_W'(1);
            end

            bus.o_drop_cnt <= drop_next_c;
            if ((&bus.i_finish) && (count == '0) && (pend == '0)) begin
                bus.o_all_done <= 1'b1;
            end
        end
    end
endmodule
